// File: rtl/regfile_pkg.sv
// Shared types and helpers for the multi-port register file.
// Holds the soft-clear state encoding and the depth derivation.
package regfile_pkg;

  typedef enum logic {
    ST_IDLE,
    ST_SWEEP
  } state_t;

  function automatic int depth_of(input int aw);
    return 1 << aw;
  endfunction

endpackage

// File: rtl/regfile_scoreboard.sv
// Pending-write scoreboard: one busy bit per register.
// Set beats clear on the same address; flush empties the whole vector.
module regfile_scoreboard
  import regfile_pkg::*;
#(
  parameter int ADDR_W = 5,
  parameter int DEPTH  = 32,
  parameter bit ZR     = 1'b1
) (
  input  logic              clk,
  input  logic              clr_n,
  input  logic              flush,
  input  logic              set,
  input  logic [ADDR_W-1:0] set_addr,
  input  logic [DEPTH-1:0]  clr_vec,
  output logic [DEPTH-1:0]  busy
);

  logic [DEPTH-1:0] nxt;

  // next busy vector: clear written entries, then apply set and flush
  always_comb begin
    nxt = busy & ~clr_vec;
    if (set) nxt[set_addr] = 1'b1;
    if (flush) nxt = '0;
    if (ZR) nxt[0] = 1'b0;
  end

  // busy vector register
  always_ff @(posedge clk) begin
    if (!clr_n) busy <= '0;
    else        busy <= nxt;
  end

endmodule

// File: rtl/regfile_mp.sv
// Multi-port GPR file with write bypass, scoreboard,
// sequenced soft clear and a registered commit trace.
module regfile_mp
  import regfile_pkg::*;
#(
  parameter int DATA_W   = 32,
  parameter int ADDR_W   = 5,
  parameter int NRD      = 2,
  parameter int NWR      = 1,
  parameter int ZERO_REG = 1
) (
  input  logic                  clk,
  input  logic                  clr_n,
  input  logic [NRD*ADDR_W-1:0] rd_addr,
  output logic [NRD*DATA_W-1:0] rd_data,
  output logic [NRD-1:0]        rd_busy,
  input  logic [NWR-1:0]        we,
  input  logic [NWR*ADDR_W-1:0] wa,
  input  logic [NWR*DATA_W-1:0] wd,
  input  logic                  sb_set,
  input  logic [ADDR_W-1:0]     sb_addr,
  input  logic                  clr_req,
  output logic                  clr_busy,
  output logic [NWR-1:0]        trace_valid,
  output logic [NWR*ADDR_W-1:0] trace_addr,
  output logic [NWR*DATA_W-1:0] trace_data
);

  localparam int DEPTH = depth_of(ADDR_W);
  localparam bit ZR = (ZERO_REG != 0);
  localparam logic [ADDR_W-1:0] LAST  = ADDR_W'(DEPTH - 1);
  localparam logic [ADDR_W-1:0] FIRST = ADDR_W'(ZR);

  logic [DATA_W-1:0] mem [DEPTH];
  state_t            state, state_nxt;
  logic [ADDR_W-1:0] cnt, cnt_nxt;
  logic [NWR-1:0]    eff;
  logic [DEPTH-1:0]  clr_vec;
  logic [DEPTH-1:0]  sb_bits;
  logic              flush;

  // effective writes: idle only, never to the hardwired zero entry
  always_comb begin
    eff = '0;
    clr_vec = '0;
    for (int k = 0; k < NWR; k++) begin
      eff[k] = we[k] && (state == ST_IDLE) &&
               (!ZR || wa[k*ADDR_W +: ADDR_W] != '0);
      if (eff[k]) clr_vec[wa[k*ADDR_W +: ADDR_W]] = 1'b1;
    end
  end

  // soft-clear sequencer next state and sweep counter
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    flush     = 1'b0;
    unique case (state)
      ST_IDLE: begin
        if (clr_req) begin
          state_nxt = ST_SWEEP;
          cnt_nxt   = FIRST;
          flush     = 1'b1;
        end
      end
      ST_SWEEP: begin
        cnt_nxt = cnt + 1'b1;
        if (cnt == LAST) state_nxt = ST_IDLE;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  // state and counter registers
  always_ff @(posedge clk) begin
    if (!clr_n) begin
      state <= ST_IDLE;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

  assign clr_busy = (state == ST_SWEEP);

  // array update: sweep zeroes one entry, else highest port wins
  always_ff @(posedge clk) begin
    if (!clr_n) begin
      for (int j = 0; j < DEPTH; j++) mem[j] <= '0;
    end else if (state == ST_SWEEP) begin
      mem[cnt] <= '0;
    end else begin
      for (int k = 0; k < NWR; k++)
        if (eff[k])
          mem[wa[k*ADDR_W +: ADDR_W]] <= wd[k*DATA_W +: DATA_W];
    end
  end

  // read ports with same-cycle write bypass
  always_comb begin
    rd_data = '0;
    rd_busy = '0;
    for (int i = 0; i < NRD; i++) begin
      rd_data[i*DATA_W +: DATA_W] = mem[rd_addr[i*ADDR_W +: ADDR_W]];
      for (int k = 0; k < NWR; k++)
        if (eff[k] && wa[k*ADDR_W +: ADDR_W] == rd_addr[i*ADDR_W +: ADDR_W])
          rd_data[i*DATA_W +: DATA_W] = wd[k*DATA_W +: DATA_W];
      if (ZR && rd_addr[i*ADDR_W +: ADDR_W] == '0)
        rd_data[i*DATA_W +: DATA_W] = '0;
      rd_busy[i] = sb_bits[rd_addr[i*ADDR_W +: ADDR_W]];
    end
  end

  // commit trace, one record per effective port
  always_ff @(posedge clk) begin
    if (!clr_n) begin
      trace_valid <= '0;
      trace_addr  <= '0;
      trace_data  <= '0;
    end else begin
      trace_valid <= eff;
      for (int k = 0; k < NWR; k++)
        if (eff[k]) begin
          trace_addr[k*ADDR_W +: ADDR_W] <= wa[k*ADDR_W +: ADDR_W];
          trace_data[k*DATA_W +: DATA_W] <= wd[k*DATA_W +: DATA_W];
        end
    end
  end

  regfile_scoreboard #(
    .ADDR_W (ADDR_W),
    .DEPTH  (DEPTH),
    .ZR     (ZR)
  ) u_sb (
    .clk      (clk),
    .clr_n    (clr_n),
    .flush    (flush),
    .set      (sb_set && state == ST_IDLE),
    .set_addr (sb_addr),
    .clr_vec  (clr_vec),
    .busy     (sb_bits)
  );

endmodule

// File: tb/tb_regfile_mp.sv
// Directed bench for regfile_mp with two read and two write ports.
// Expected values are hand-derived constants per step.
module tb_regfile_mp;

  logic        clk = 1'b0;
  logic        clr_n;
  logic [9:0]  rd_addr;
  logic [63:0] rd_data;
  logic [1:0]  rd_busy;
  logic [1:0]  we;
  logic [9:0]  wa;
  logic [63:0] wd;
  logic        sb_set;
  logic [4:0]  sb_addr;
  logic        clr_req;
  logic        clr_busy;
  logic [1:0]  trace_valid;
  logic [9:0]  trace_addr;
  logic [63:0] trace_data;

  int checks = 0;
  int errors = 0;
  int n;

  regfile_mp #(
    .DATA_W   (32),
    .ADDR_W   (5),
    .NRD      (2),
    .NWR      (2),
    .ZERO_REG (1)
  ) dut (
    .clk         (clk),
    .clr_n       (clr_n),
    .rd_addr     (rd_addr),
    .rd_data     (rd_data),
    .rd_busy     (rd_busy),
    .we          (we),
    .wa          (wa),
    .wd          (wd),
    .sb_set      (sb_set),
    .sb_addr     (sb_addr),
    .clr_req     (clr_req),
    .clr_busy    (clr_busy),
    .trace_valid (trace_valid),
    .trace_addr  (trace_addr),
    .trace_data  (trace_data)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs,
                     input logic [63:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic rd(input logic [4:0] a0, input logic [4:0] a1);
    rd_addr = {a1, a0};
    #1;
  endtask

  task automatic all_zero(input string tag);
    for (int a = 0; a < 32; a++) begin
      rd(5'(a), 5'(a));
      chk({tag, "_data"}, rd_data, 64'h0);
      chk({tag, "_busy"}, 64'(rd_busy), 64'h0);
    end
  endtask

  initial begin
    clr_n = 1'b0;
    rd_addr = '0;
    we = '0;
    wa = '0;
    wd = '0;
    sb_set = 1'b0;
    sb_addr = '0;
    clr_req = 1'b0;
    tick();
    tick();
    clr_n = 1'b1;
    #1;

    // reset state
    all_zero("reset");
    chk("reset_tv", 64'(trace_valid), 64'h0);
    chk("reset_cb", 64'(clr_busy), 64'h0);

    // write $5 on port 0, bypass then trace
    we = 2'b01;
    wa = {5'd0, 5'd5};
    wd = {32'h0, 32'hDEADBEEF};
    rd(5'd5, 5'd5);
    chk("byp5_p0", 64'(rd_data[31:0]), 64'hDEADBEEF);
    chk("byp5_p1", 64'(rd_data[63:32]), 64'hDEADBEEF);
    tick();
    we = '0;
    #1;
    chk("tr5_valid", 64'(trace_valid), 64'h1);
    chk("tr5_addr", 64'(trace_addr[4:0]), 64'd5);
    chk("tr5_data", 64'(trace_data[31:0]), 64'hDEADBEEF);
    chk("arr5", 64'(rd_data[31:0]), 64'hDEADBEEF);
    tick();
    chk("tr5_drop", 64'(trace_valid), 64'h0);
    chk("tr5_hold", 64'(trace_data[31:0]), 64'hDEADBEEF);

    // write to $0 is discarded
    we = 2'b01;
    wa = {5'd0, 5'd0};
    wd = {32'h0, 32'h1234};
    rd(5'd0, 5'd5);
    chk("zero_byp", 64'(rd_data[31:0]), 64'h0);
    tick();
    we = '0;
    #1;
    chk("zero_tv", 64'(trace_valid), 64'h0);
    chk("zero_arr", 64'(rd_data[31:0]), 64'h0);

    // two ports to $7, port 1 wins
    we = 2'b11;
    wa = {5'd7, 5'd7};
    wd = {32'h22, 32'h11};
    rd(5'd7, 5'd5);
    chk("prio_byp", 64'(rd_data[31:0]), 64'h22);
    chk("prio_other", 64'(rd_data[63:32]), 64'hDEADBEEF);
    tick();
    we = '0;
    #1;
    chk("prio_tv", 64'(trace_valid), 64'h3);
    chk("prio_ta", 64'(trace_addr), 64'({5'd7, 5'd7}));
    chk("prio_td", trace_data, {32'h22, 32'h11});
    chk("prio_arr", 64'(rd_data[31:0]), 64'h22);

    // scoreboard set, not bypassed
    sb_set = 1'b1;
    sb_addr = 5'd9;
    rd(5'd9, 5'd7);
    chk("sb_nobyp", 64'(rd_busy), 64'h0);
    tick();
    sb_set = 1'b0;
    #1;
    chk("sb_set", 64'(rd_busy), 64'h1);
    we = 2'b01;
    wa = {5'd0, 5'd9};
    wd = {32'h0, 32'h99};
    tick();
    we = '0;
    #1;
    chk("sb_clr", 64'(rd_busy), 64'h0);

    // set beats same-cycle clear
    sb_set = 1'b1;
    we = 2'b10;
    wa = {5'd9, 5'd0};
    wd = {32'h9A, 32'h0};
    tick();
    sb_set = 1'b0;
    we = '0;
    #1;
    chk("sb_setwins", 64'(rd_busy), 64'h1);
    chk("sb_wr_data", 64'(rd_data[31:0]), 64'h9A);
    we = 2'b01;
    wa = {5'd0, 5'd9};
    tick();
    we = '0;
    #1;
    chk("sb_clr2", 64'(rd_busy), 64'h0);

    // fill $1..$31 with their index, leave $3 busy
    for (int a = 1; a < 32; a++) begin
      we = 2'b01;
      wa = {5'd0, 5'(a)};
      wd = {32'h0, 32'(a)};
      sb_set = (a == 31);
      sb_addr = 5'd3;
      tick();
    end
    we = '0;
    sb_set = 1'b0;
    rd(5'd31, 5'd3);
    chk("fill31", rd_data, {32'd3, 32'd31});
    chk("fill_busy", 64'(rd_busy), 64'h2);

    // soft clear with writes and sb_set attempted during sweep
    clr_req = 1'b1;
    tick();
    clr_req = 1'b0;
    chk("cb_rise", 64'(clr_busy), 64'h1);
    we = 2'b11;
    wa = {5'd4, 5'd6};
    wd = {32'hFFFF, 32'hEEEE};
    sb_set = 1'b1;
    sb_addr = 5'd6;
    rd(5'd6, 5'd4);
    chk("sw_nobyp", 64'(rd_data[31:0]), 64'd6);
    n = 0;
    while (clr_busy && n < 100) begin
      n++;
      tick();
      if (n == 5) chk("sw_tv", 64'(trace_valid), 64'h0);
    end
    we = '0;
    sb_set = 1'b0;
    chk("sw_len", 64'(n), 64'd31);
    all_zero("swept");

    // first write after sweep is accepted
    we = 2'b01;
    wa = {5'd0, 5'd4};
    wd = {32'h0, 32'h44};
    rd(5'd4, 5'd0);
    chk("post_byp", 64'(rd_data[31:0]), 64'h44);
    tick();
    we = '0;
    #1;
    chk("post_tv", 64'(trace_valid), 64'h1);
    chk("post_arr", 64'(rd_data[31:0]), 64'h44);

    // reset during sweep cycle 10
    we = 2'b01;
    wa = {5'd0, 5'd20};
    wd = {32'h0, 32'hABCD};
    tick();
    we = '0;
    clr_req = 1'b1;
    tick();
    clr_req = 1'b0;
    for (int c = 1; c < 10; c++) tick();
    chk("mid_busy", 64'(clr_busy), 64'h1);
    rd(5'd20, 5'd4);
    chk("mid_20", 64'(rd_data[31:0]), 64'hABCD);
    clr_n = 1'b0;
    tick();
    clr_n = 1'b1;
    #1;
    chk("rst_cb", 64'(clr_busy), 64'h0);
    chk("rst_tv", 64'(trace_valid), 64'h0);
    chk("rst_ta", 64'(trace_addr), 64'h0);
    chk("rst_td", trace_data, 64'h0);
    all_zero("rst_mid");
    tick();
    chk("rst_stay", 64'(clr_busy), 64'h0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
